// File: rtl/grey_pkg.sv
// Shared types and Gray-code helpers for the grey_meter event counter.
package grey_pkg;

  localparam int cSYNC_STAGES = 2;
  localparam int cMAXW        = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  function automatic logic [cMAXW-1:0] bin2gray(input logic [cMAXW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Narrower codes are passed zero-extended; leading zeros decode to zeros.
  function automatic logic [cMAXW-1:0] gray2bin(input logic [cMAXW-1:0] g);
    logic [cMAXW-1:0] b;
    b[cMAXW-1] = g[cMAXW-1];
    for (int i = cMAXW-2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

endpackage

// File: rtl/grey_chan.sv
// One measured channel: synchroniser, rising-edge strobe, Gray counter and sticky wrap flag.
module grey_chan
  import grey_pkg::*;
#(
  parameter int pWIDTH = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cnt,
  input  logic              en,
  input  logic              clr,
  output logic [pWIDTH-1:0] gray,
  output logic              ovf
);

  // sh[0..cSYNC_STAGES-1] synchronise, sh[cSYNC_STAGES] is the history flop
  logic [cSYNC_STAGES:0] sh;
  logic                  strobe;
  logic [pWIDTH-1:0]     bin, bin_inc;

  assign strobe  = sh[cSYNC_STAGES-1] & ~sh[cSYNC_STAGES];
  assign bin     = pWIDTH'(gray2bin(cMAXW'(gray)));
  assign bin_inc = bin + pWIDTH'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      sh   <= '0;
      gray <= '0;
      ovf  <= 1'b0;
    end else begin
      sh <= {sh[cSYNC_STAGES-1:0], cnt};
      if (clr) begin
        gray <= '0;
        ovf  <= 1'b0;
      end else if (en && strobe) begin
        gray <= pWIDTH'(bin2gray(cMAXW'(bin_inc)));
        if (&bin) ovf <= 1'b1;
      end
    end
  end

  a_one_bit: assert property (@(posedge clk) disable iff (rst)
    !$past(clr || rst) |-> ($countones(gray ^ $past(gray)) <= 1));

endmodule

// File: rtl/grey_meter.sv
// Multi-channel gated event meter: windowed Gray counting, snapshot bank and registered readout.
module grey_meter
  import grey_pkg::*;
#(
  parameter int  pCHANNELS = 7,
  parameter int  pWIDTH    = 10,
  parameter int  pGATE     = 1024,
  localparam int pSELW     = (pCHANNELS > 1) ? $clog2(pCHANNELS) : 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [pCHANNELS-1:0] i_cnt,
  input  logic [pCHANNELS-1:0] i_en_mask,
  input  logic                 i_mode,
  input  logic                 i_start,
  input  logic                 i_stop,
  input  logic [pSELW-1:0]     i_rd_sel,
  output logic                 o_busy,
  output logic                 o_valid,
  output logic [pWIDTH-1:0]    o_rd_gray,
  output logic [pWIDTH-1:0]    o_rd_bin,
  output logic                 o_rd_ovf,
  output logic                 o_ovf_any
);

  localparam int GW = $clog2(pGATE);

  state_t                            state;
  logic [GW-1:0]                     gate;
  logic [pCHANNELS-1:0][pWIDTH-1:0]  live, snap, snap_nxt;
  logic [pCHANNELS-1:0]              live_ovf, snap_ovf, ovf_nxt;
  logic                              run, cap, clr, sel_ok;

  assign run = (state == RUN);
  assign cap = (state == CAPTURE);
  assign clr = (state == IDLE && i_start) || (run && i_stop) || cap;

  for (genvar c = 0; c < pCHANNELS; c++) begin : g_chan
    grey_chan #(.pWIDTH(pWIDTH)) u_chan (
      .clk  (i_clk),
      .rst  (i_rst),
      .cnt  (i_cnt[c]),
      .en   (i_en_mask[c] & run),
      .clr  (clr),
      .gray (live[c]),
      .ovf  (live_ovf[c])
    );
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= IDLE;
      gate     <= '0;
      snap     <= '0;
      snap_ovf <= '0;
      o_busy   <= 1'b0;
      o_valid  <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      unique case (state)
        IDLE: if (i_start) begin
          state  <= RUN;
          gate   <= '0;
          o_busy <= 1'b1;
        end
        RUN: begin
          if (i_stop) begin
            state  <= IDLE;
            o_busy <= 1'b0;
          end else if (gate == GW'(pGATE-1)) begin
            state <= CAPTURE;
          end else begin
            gate <= gate + GW'(1);
          end
        end
        CAPTURE: begin
          snap     <= live;
          snap_ovf <= live_ovf;
          o_valid  <= 1'b1;
          gate     <= '0;
          if (i_mode && !i_stop) begin
            state <= RUN;
          end else begin
            state  <= IDLE;
            o_busy <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

  // Read from the value the bank is about to hold so readout lines up with o_valid.
  assign snap_nxt = cap ? live : snap;
  assign ovf_nxt  = cap ? live_ovf : snap_ovf;
  assign sel_ok   = ({1'b0, i_rd_sel} < (pSELW+1)'(pCHANNELS));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rd_gray <= '0;
      o_rd_bin  <= '0;
      o_rd_ovf  <= 1'b0;
      o_ovf_any <= 1'b0;
    end else begin
      o_ovf_any <= |ovf_nxt;
      if (sel_ok) begin
        o_rd_gray <= snap_nxt[i_rd_sel];
        o_rd_bin  <= pWIDTH'(gray2bin(cMAXW'(snap_nxt[i_rd_sel])));
        o_rd_ovf  <= ovf_nxt[i_rd_sel];
      end else begin
        o_rd_gray <= '0;
        o_rd_bin  <= '0;
        o_rd_ovf  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_grey_meter.sv
// Bench for grey_meter: cycle-level counting model compared every clock, plus literal pins.
module tb_grey_meter;

  localparam int C  = 7;
  localparam int W  = 3;
  localparam int G  = 20;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [C-1:0]  cnt = '0;
  logic [C-1:0]  mask = '1;
  logic          mode = 1'b0, start = 1'b0, stop = 1'b0;
  logic [SW-1:0] sel = '0;
  logic          busy, valid, rd_ovf, ovf_any;
  logic [W-1:0]  rd_gray, rd_bin;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  grey_meter #(.pCHANNELS(C), .pWIDTH(W), .pGATE(G)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_cnt     (cnt),
    .i_en_mask (mask),
    .i_mode    (mode),
    .i_start   (start),
    .i_stop    (stop),
    .i_rd_sel  (sel),
    .o_busy    (busy),
    .o_valid   (valid),
    .o_rd_gray (rd_gray),
    .o_rd_bin  (rd_bin),
    .o_rd_ovf  (rd_ovf),
    .o_ovf_any (ovf_any)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Event sources: per[c]==0 gives random bits, otherwise a square wave of that period.
  int per[C];
  int tick = 0;
  always @(negedge clk) begin
    tick++;
    for (int c = 0; c < C; c++)
      cnt[c] = (per[c] == 0) ? 1'($urandom_range(0, 1)) : ((tick % per[c]) < per[c] / 2);
  end

  // Model: phase 0 idle, 1 counting window, 2 capture; counts kept as plain integers.
  int  m_phase = 0, m_gate = 0;
  int  m_live[C], m_snap[C];
  bit  m_lovf[C], m_sovf[C];
  bit [C-1:0] p1 = '0, p2 = '0, p3 = '0;
  bit  e_valid = 0, e_busy = 0, e_rovf = 0, e_any = 0;
  int  e_bin = 0, e_gray = 0;

  always @(posedge clk) begin
    bit [C-1:0] rise;
    if (rst) begin
      m_phase = 0; m_gate = 0;
      for (int c = 0; c < C; c++) begin
        m_live[c] = 0; m_snap[c] = 0; m_lovf[c] = 0; m_sovf[c] = 0;
      end
      p1 = '0; p2 = '0; p3 = '0;
      e_valid = 0; e_busy = 0; e_rovf = 0; e_any = 0; e_bin = 0; e_gray = 0;
    end else begin
      // a rise presented to the input is seen as an edge two clocks later
      rise = p2 & ~p3;
      if (m_phase == 1)
        for (int c = 0; c < C; c++)
          if (rise[c] && mask[c]) begin
            m_live[c]++;
            if (m_live[c] == (1 << W)) begin
              m_live[c] = 0;
              m_lovf[c] = 1;
            end
          end
      e_valid = 0;
      case (m_phase)
        0: if (start) begin
          for (int c = 0; c < C; c++) begin m_live[c] = 0; m_lovf[c] = 0; end
          m_gate = 0; m_phase = 1;
        end
        1: if (stop) begin
          for (int c = 0; c < C; c++) begin m_live[c] = 0; m_lovf[c] = 0; end
          m_phase = 0;
        end else begin
          m_gate++;
          if (m_gate == G) m_phase = 2;
        end
        default: begin
          for (int c = 0; c < C; c++) begin
            m_snap[c] = m_live[c]; m_sovf[c] = m_lovf[c];
            m_live[c] = 0; m_lovf[c] = 0;
          end
          e_valid = 1; m_gate = 0;
          m_phase = (mode && !stop) ? 1 : 0;
        end
      endcase
      e_busy = (m_phase != 0);
      e_bin  = (int'(sel) < C) ? m_snap[sel] : 0;
      e_rovf = (int'(sel) < C) ? m_sovf[sel] : 0;
      e_gray = e_bin ^ (e_bin >> 1);
      e_any  = 0;
      for (int c = 0; c < C; c++) e_any |= m_sovf[c];
      p3 = p2; p2 = p1; p1 = cnt;
    end
  end

  always @(posedge clk) begin
    #1;
    chk("valid",   valid,   e_valid);
    chk("busy",    busy,    e_busy);
    chk("rd_bin",  rd_bin,  e_bin);
    chk("rd_gray", rd_gray, e_gray);
    chk("rd_ovf",  rd_ovf,  e_rovf);
    chk("ovf_any", ovf_any, e_any);
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Returns the number of clocks waited; a timeout is recorded as a failed check.
  task automatic wait_valid(input string name, input int max, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!valid && n < max);
    if (!valid) chk({name, "_timeout"}, 0, 1);
  endtask

  int n, seen;

  initial begin
    for (int c = 0; c < C; c++) per[c] = 0;
    repeat (3) @(negedge clk);
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_bin", rd_bin, 0);
    chk("rst_any", ovf_any, 0);
    rst = 1'b0;
    per[0] = 4; per[1] = 2;
    repeat (8) @(negedge clk);

    // single shot: 20-cycle window, period 4 -> 5 edges, period 2 -> 10 edges (wraps at 8)
    sel = 0; mode = 0;
    pulse_start();
    chk("ss_busy", busy, 1);
    wait_valid("ss", 60, n);
    chk("ss_latency", n, G + 1);
    chk("ss_bin", rd_bin, 5);
    chk("ss_gray", rd_gray, 7);
    chk("ss_ovf", rd_ovf, 0);
    chk("ss_idle", busy, 0);
    sel = 1;
    @(negedge clk);
    chk("ovf_bin", rd_bin, 2);
    chk("ovf_gray", rd_gray, 3);
    chk("ovf_flag", rd_ovf, 1);
    chk("ovf_any", ovf_any, 1);

    // continuous with ch2 masked
    sel = 0; mode = 1; mask[2] = 1'b0;
    pulse_start();
    wait_valid("c0", 60, n);
    chk("cont_bin0", rd_bin, 5);
    sel = 2;
    wait_valid("c1", 60, n);
    chk("cont_period1", n, G + 1);
    chk("mask_bin", rd_bin, 0);
    sel = 0;
    wait_valid("c2", 60, n);
    chk("cont_period2", n, G + 1);
    chk("cont_bin2", rd_bin, 5);
    mode = 0;
    wait_valid("c3", 60, n);
    chk("cont_end_busy", busy, 0);
    mask = '1;
    repeat (3) @(negedge clk);

    // stop during the 8th counting cycle
    pulse_start();
    repeat (7) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("stop_busy", busy, 0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (valid) seen++;
    end
    chk("stop_novalid", seen, 0);
    chk("stop_keep", rd_bin, 5);

    // out-of-range select
    sel = 7;
    @(negedge clk);
    chk("sel_bin", rd_bin, 0);
    chk("sel_gray", rd_gray, 0);
    chk("sel_ovf", rd_ovf, 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if (i % 250 == 0)
        for (int c = 0; c < C; c++) per[c] = $urandom_range(0, 3) * 2;
      mask  = C'($urandom) | C'($urandom);
      sel   = SW'($urandom_range(0, 7));
      start = ($urandom_range(0, 19) == 0);
      stop  = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 49) == 0) mode = 1'($urandom_range(0, 1));
      rst   = ($urandom_range(0, 599) == 0);
      @(negedge clk);
    end
    start = 0; stop = 0; rst = 0;

    // reset in the middle of a window with inputs toggling
    per[0] = 2; per[1] = 2; mode = 1; mask = '1; sel = 1;
    repeat (4) @(negedge clk);
    pulse_start();
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_busy", busy, 0);
    chk("mrst_valid", valid, 0);
    chk("mrst_bin", rd_bin, 0);
    chk("mrst_gray", rd_gray, 0);
    chk("mrst_ovf", rd_ovf, 0);
    chk("mrst_any", ovf_any, 0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (valid) seen++;
    end
    chk("mrst_novalid", seen, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
